// File: rtl/tv80_dma_pkg.sv
// Shared types and widths for the tv80 bus-request DMA loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tv80_dma_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int TO_W   = 8;
  localparam int WC_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    XFER,
    WRITE,
    REL
  } dma_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] dat;
    logic              mreq_n;
    logic              rd_n;
    logic              wr_n;
  } mem_bus_t;

endpackage

// File: rtl/tv80_bus_mux.sv
// Memory-side select between the CPU bus and the DMA write port.
// Latency: combinational.
// Backpressure: none; the owner flag alone decides who drives.
module tv80_bus_mux
  import tv80_dma_pkg::*;
(
  input  logic              owner,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [DATA_W-1:0] cpu_do,
  input  logic              cpu_mreq_n,
  input  logic              cpu_rd_n,
  input  logic              cpu_wr_n,
  input  logic [ADDR_W-1:0] dma_a,
  input  logic [DATA_W-1:0] dma_do,
  input  logic              dma_strb_n,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_do,
  output logic              mem_mreq_n,
  output logic              mem_rd_n,
  output logic              mem_wr_n
);

  mem_bus_t cpu_bus;
  mem_bus_t dma_bus;
  mem_bus_t mem_bus;

  // The DMA side only ever writes, so its read strobe is tied inactive.
  always_comb begin
    cpu_bus = '{a: cpu_a, dat: cpu_do, mreq_n: cpu_mreq_n, rd_n: cpu_rd_n, wr_n: cpu_wr_n};
    dma_bus = '{a: dma_a, dat: dma_do, mreq_n: dma_strb_n, rd_n: 1'b1, wr_n: dma_strb_n};
    mem_bus = owner ? dma_bus : cpu_bus;
  end

  assign mem_a      = mem_bus.a;
  assign mem_do     = mem_bus.dat;
  assign mem_mreq_n = mem_bus.mreq_n;
  assign mem_rd_n   = mem_bus.rd_n;
  assign mem_wr_n   = mem_bus.wr_n;

endmodule

// File: rtl/tv80_dma_arbiter.sv
// Takes the tv80 bus via BUSRQ/BUSAK and bursts a byte stream into consecutive addresses.
// Latency: one byte per WR_CYCLES+1 cycles once the bus is granted.
// Backpressure: dat_ready only in XFER with the bus held; losing BUSAK aborts the burst.
module tv80_dma_arbiter
  import tv80_dma_pkg::*;
#(
  parameter int WR_CYCLES   = 1,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [15:0]       len,
  input  logic [DATA_W-1:0] dat,
  input  logic              dat_valid,
  output logic              dat_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              owner,
  output logic              cpu_busrq_n,
  input  logic              cpu_busak_n,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [DATA_W-1:0] cpu_do,
  input  logic              cpu_mreq_n,
  input  logic              cpu_rd_n,
  input  logic              cpu_wr_n,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_do,
  output logic              mem_mreq_n,
  output logic              mem_rd_n,
  output logic              mem_wr_n
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WR_CYCLES - 1);

  dma_state_t        state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       count;
  logic [DATA_W-1:0] data_r;
  logic [TO_W-1:0]   to_cnt;
  logic [WC_W-1:0]   wr_cnt;
  logic              done_r;
  logic              err_r;

  logic start_ok, zero_start, byte_acc, wr_last, abort, timeout, rel_done;
  logic in_bus, to_hit, dma_strb_n;

  assign to_hit = (ACK_TIMEOUT != 0) && (to_cnt == TO_LAST);

  always_comb begin
    state_nx   = state;
    start_ok   = 1'b0;
    zero_start = 1'b0;
    byte_acc   = 1'b0;
    wr_last    = 1'b0;
    abort      = 1'b0;
    timeout    = 1'b0;
    rel_done   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == 16'd0) begin
            zero_start = 1'b1;
          end else begin
            start_ok = 1'b1;
            state_nx = REQ;
          end
        end
      end
      REQ: begin
        if (!cpu_busak_n) begin
          state_nx = XFER;
        end else if (to_hit) begin
          timeout  = 1'b1;
          state_nx = REL;
        end
      end
      XFER: begin
        if (cpu_busak_n) begin
          abort    = 1'b1;
          state_nx = REL;
        end else if (dat_valid) begin
          byte_acc = 1'b1;
          state_nx = WRITE;
        end
      end
      WRITE: begin
        if (cpu_busak_n) begin
          abort    = 1'b1;
          state_nx = REL;
        end else if (wr_cnt == WC_LAST) begin
          wr_last  = 1'b1;
          state_nx = (count == 16'd1) ? REL : XFER;
        end
      end
      REL: begin
        if (cpu_busak_n) begin
          rel_done = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      addr   <= '0;
      count  <= '0;
      data_r <= '0;
      to_cnt <= '0;
      wr_cnt <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      state  <= state_nx;
      done_r <= zero_start | rel_done;
      if (zero_start | start_ok) begin
        err_r <= 1'b0;
      end else if (abort | timeout) begin
        err_r <= 1'b1;
      end
      if (start_ok) begin
        addr   <= base;
        count  <= len;
        to_cnt <= '0;
      end else if (state == REQ) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (byte_acc) begin
        data_r <= dat;
        wr_cnt <= '0;
      end else if (state == WRITE) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (wr_last) begin
        addr  <= addr + 16'd1;
        count <= count - 16'd1;
      end
    end
  end

  // Gating ownership with BUSAK means a lost grant drops the DMA drivers in the same cycle.
  assign in_bus      = (state == XFER) || (state == WRITE);
  assign owner       = in_bus && !cpu_busak_n;
  assign dat_ready   = (state == XFER) && !cpu_busak_n;
  assign cpu_busrq_n = !((state == REQ) || in_bus);
  assign busy        = (state != IDLE);
  assign done        = done_r;
  assign err         = err_r;
  assign dma_strb_n  = (state != WRITE);

  tv80_bus_mux u_mux (
    .owner      (owner),
    .cpu_a      (cpu_a),
    .cpu_do     (cpu_do),
    .cpu_mreq_n (cpu_mreq_n),
    .cpu_rd_n   (cpu_rd_n),
    .cpu_wr_n   (cpu_wr_n),
    .dma_a      (addr),
    .dma_do     (data_r),
    .dma_strb_n (dma_strb_n),
    .mem_a      (mem_a),
    .mem_do     (mem_do),
    .mem_mreq_n (mem_mreq_n),
    .mem_rd_n   (mem_rd_n),
    .mem_wr_n   (mem_wr_n)
  );

endmodule

// File: tb/tb_tv80_dma_arbiter.sv
// Randomised bench for tv80_dma_arbiter: emulated CPU grant, byte stream, memory and write scoreboard.
module tb_tv80_dma_arbiter;

  localparam int WR_CYCLES   = 2;
  localparam int ACK_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] base;
  logic [15:0] len;
  logic [7:0]  dat;
  logic        dat_valid;
  logic        dat_ready;
  logic        busy, done, err, owner;
  logic        cpu_busrq_n;
  logic        cpu_busak_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do;
  logic        cpu_mreq_n, cpu_rd_n, cpu_wr_n;
  logic [15:0] mem_a;
  logic [7:0]  mem_do;
  logic        mem_mreq_n, mem_rd_n, mem_wr_n;

  always #5 clk = ~clk;

  tv80_dma_arbiter #(.WR_CYCLES(WR_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base(base), .len(len),
    .dat(dat), .dat_valid(dat_valid), .dat_ready(dat_ready),
    .busy(busy), .done(done), .err(err), .owner(owner),
    .cpu_busrq_n(cpu_busrq_n), .cpu_busak_n(cpu_busak_n),
    .cpu_a(cpu_a), .cpu_do(cpu_do),
    .cpu_mreq_n(cpu_mreq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .mem_a(mem_a), .mem_do(mem_do),
    .mem_mreq_n(mem_mreq_n), .mem_rd_n(mem_rd_n), .mem_wr_n(mem_wr_n)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:65535];
  logic [23:0] exp_q [$];
  logic [7:0]  stream_q [$];
  logic [7:0]  src [0:15];

  bit   force_hi = 1'b0;
  bit   stall = 1'b0;
  bit   gaps = 1'b0;
  bit   thr_on = 1'b0;
  bit   hs = 1'b0;
  int   ack_lat = 1;
  int   ack_cnt = 0;
  int   done_cnt = 0;
  int   writes_seen = 0;
  int   cyc = 0;
  int   last_start = -1;
  int   pulse = 0;
  logic wr_prev = 1'b0;
  logic [15:0] cur_a;
  logic [7:0]  cur_d;
  logic [23:0] e;
  logic [2:0]  r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // CPU and stream emulation, updated just after each rising edge.
  initial begin
    cpu_busak_n = 1'b1;
    dat_valid = 1'b0;
    dat = 8'h00;
    cpu_a = 16'h0000; cpu_do = 8'h00;
    cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (hs && stream_q.size() > 0) void'(stream_q.pop_front());
      if (stream_q.size() > 0 && !stall && (!gaps || $urandom_range(0, 2) != 0)) begin
        dat_valid = 1'b1;
        dat = stream_q[0];
      end else begin
        dat_valid = 1'b0;
        dat = 8'($urandom);
      end
      // CPU never writes, so every memory write observed belongs to the DMA.
      r = 3'($urandom);
      if (!r[2] && !r[0]) r[0] = 1'b1;
      {cpu_mreq_n, cpu_rd_n, cpu_wr_n} = r;
      cpu_a = 16'($urandom);
      cpu_do = 8'($urandom);
      if (force_hi) begin
        cpu_busak_n = 1'b1; ack_cnt = 0;
      end else if (!cpu_busrq_n) begin
        if (ack_cnt >= ack_lat) cpu_busak_n = 1'b0;
        else ack_cnt++;
      end else begin
        cpu_busak_n = 1'b1; ack_cnt = 0;
      end
    end
  end

  // Per-cycle compare against the bus rules and the expected write sequence.
  always @(negedge clk) begin
    cyc++;
    hs = dat_valid && dat_ready && reset_n;
    if (done === 1'b1) begin
      done_cnt++;
      chk("done_busy", busy, 0);
    end
    if (owner === 1'b1) begin
      chk("own_grant", {cpu_busak_n, cpu_busrq_n}, 2'b00);
      chk("own_strb", {mem_rd_n, mem_mreq_n}, {1'b1, mem_wr_n});
    end else begin
      chk("passthru", {mem_a, mem_do, mem_mreq_n, mem_rd_n, mem_wr_n},
          {cpu_a, cpu_do, cpu_mreq_n, cpu_rd_n, cpu_wr_n});
    end
    if (dat_ready === 1'b1) chk("rdy_owner", {owner, mem_mreq_n}, 2'b11);
    if (!mem_mreq_n && !mem_wr_n) begin
      mem[mem_a] = mem_do;
      if (!wr_prev) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_wr", {8'h00, mem_a, mem_do}, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", mem_a, e[23:8]);
          chk("wr_data", mem_do, e[7:0]);
        end
        if (thr_on && last_start >= 0) chk("throughput", cyc - last_start, WR_CYCLES + 1);
        last_start = cyc;
        pulse = 1;
        cur_a = mem_a;
        cur_d = mem_do;
      end else begin
        pulse++;
        chk("wr_hold", {mem_a, mem_do}, {cur_a, cur_d});
      end
      wr_prev = 1'b1;
    end else begin
      if (wr_prev && !force_hi) chk("wr_pulse", pulse, WR_CYCLES);
      wr_prev = 1'b0;
    end
  end

  task automatic pulse_start(input logic [15:0] b, input logic [15:0] n);
    @(posedge clk); #1;
    base = b; len = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base = 16'($urandom); len = 16'($urandom);
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 400) begin
      @(negedge clk); t++;
    end
    chk("done_seen", done_cnt != d0, 1);
  endtask

  task automatic load(input logic [15:0] b, input int n, input bit to_exp);
    logic [15:0] ai;
    for (int i = 0; i < n; i++) begin
      ai = b + 16'(i);
      if (to_exp) exp_q.push_back({ai, src[i]});
      stream_q.push_back(src[i]);
    end
  endtask

  task automatic run_xfer(input logic [15:0] b, input int n, input bit gap_en);
    int d0, w0;
    d0 = done_cnt; w0 = writes_seen;
    gaps = gap_en; thr_on = !gap_en; last_start = -1;
    load(b, n, 1'b1);
    pulse_start(b, 16'(n));
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    chk("busrq_low", cpu_busrq_n, 0);
    chk("err_cleared", err, 0);
    wait_done(d0);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("err_ok", err, 0);
    chk("writes", writes_seen - w0, n);
    chk("exp_left", exp_q.size(), 0);
    chk("idle_end", {busy, owner, cpu_busrq_n}, 3'b001);
    thr_on = 1'b0;
  endtask

  initial begin
    int d0, w0, t, nreq, lows;
    reset_n = 1'b0; start = 1'b0; base = 16'h0000; len = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_state", {cpu_busrq_n, dat_ready, busy, done, err, owner}, 6'b100000);
    chk("rst_mux", mem_a, cpu_a);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed load, stream held valid, then literal memory contents.
    src[0] = 8'hCB; src[1] = 8'h33; src[2] = 8'hBA;
    ack_lat = 2;
    run_xfer(16'h038F, 3, 1'b0);
    chk("mem_038F", mem[16'h038F], 8'hCB);
    chk("mem_0390", mem[16'h0390], 8'h33);
    chk("mem_0391", mem[16'h0391], 8'hBA);

    // Address wrap.
    src[0] = 8'h11; src[1] = 8'h22;
    run_xfer(16'hFFFF, 2, 1'b1);
    chk("mem_FFFF", mem[16'hFFFF], 8'h11);
    chk("mem_0000", mem[16'h0000], 8'h22);

    // Zero length.
    d0 = done_cnt; lows = 0;
    pulse_start(16'h2000, 16'h0000);
    @(negedge clk);
    chk("zl_done", done, 1);
    chk("zl_busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      if (!cpu_busrq_n || busy) lows++;
      @(negedge clk);
      if (i == 0) chk("zl_done_off", done, 0);
    end
    chk("zl_busrq_never", lows, 0);
    chk("zl_done_once", done_cnt - d0, 1);

    // Grant timeout.
    force_hi = 1'b1;
    d0 = done_cnt; w0 = writes_seen; nreq = 0;
    pulse_start(16'h3000, 16'd2);
    @(negedge clk);
    while (!cpu_busrq_n && nreq < 100) begin
      nreq++;
      @(negedge clk);
    end
    chk("to_req_cycles", nreq, ACK_TIMEOUT);
    wait_done(d0);
    repeat (2) @(negedge clk);
    chk("to_err", err, 1);
    chk("to_done_once", done_cnt - d0, 1);
    chk("to_no_writes", writes_seen - w0, 0);
    force_hi = 1'b0;

    // Bus loss after the first byte of four.
    src[0] = 8'hA1; src[1] = 8'hA2; src[2] = 8'hA3; src[3] = 8'hA4;
    d0 = done_cnt; w0 = writes_seen; gaps = 1'b0; stall = 1'b0;
    exp_q.push_back({16'h5000, src[0]});
    load(16'h5000, 4, 1'b0);
    pulse_start(16'h5000, 16'd4);
    @(negedge clk);
    chk("bl_err_cleared", err, 0);
    t = 0;
    while (writes_seen == w0 && t < 200) begin @(negedge clk); t++; end
    stall = 1'b1;
    t = 0;
    while (dat_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    chk("bl_in_xfer", dat_ready, 1);
    @(negedge clk);
    force_hi = 1'b1;
    wait_done(d0);
    repeat (3) @(negedge clk);
    chk("bl_writes", writes_seen - w0, 1);
    chk("bl_mem", mem[16'h5000], 8'hA1);
    chk("bl_err", err, 1);
    chk("bl_owner", owner, 0);
    chk("bl_done_once", done_cnt - d0, 1);
    stream_q.delete(); exp_q.delete();
    force_hi = 1'b0; stall = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while parked in XFER.
    src[0] = 8'h5A; src[1] = 8'h6B; src[2] = 8'h7C; src[3] = 8'h8D;
    d0 = done_cnt; w0 = writes_seen;
    load(16'h1200, 4, 1'b1);
    pulse_start(16'h1200, 16'd4);
    t = 0;
    while (writes_seen == w0 && t < 200) begin @(negedge clk); t++; end
    stall = 1'b1;
    t = 0;
    while (dat_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    chk("rst_in_xfer", dat_ready, 1);
    reset_n = 1'b0;
    exp_q.delete(); stream_q.delete();
    @(negedge clk);
    chk("rst_mid_ctl", {cpu_busrq_n, owner, busy, dat_ready}, 4'b1000);
    chk("rst_mid_mux", mem_a, cpu_a);
    @(negedge clk);
    chk("rst_mid_busy", {busy, owner}, 2'b00);
    reset_n = 1'b1; stall = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_no_more_wr", writes_seen - w0, 1);
    chk("rst_no_done", done_cnt - d0, 0);

    // Randomised transfers.
    for (int k = 0; k < 12; k++) begin
      logic [15:0] rb;
      int rn;
      rb = 16'($urandom_range(32'h8000, 32'hFFFF));
      rn = $urandom_range(1, 6);
      for (int i = 0; i < rn; i++) src[i] = 8'($urandom);
      ack_lat = $urandom_range(0, 4);
      run_xfer(rb, rn, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
